// File: rtl/imm_chunk_extender_if.sv
// Valid/ready bus for the chunked immediate extender:
// decode pushes chunks in, the ALU operand mux pulls results out.
interface imm_chunk_extender_if #(
    parameter int IN_W       = 2,
    parameter int OUT_W      = 8,
    parameter int MAX_CHUNKS = 4
);
    localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_chunk;
    logic             in_last;
    logic             in_sext;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic             out_ovf;
    logic [CNT_W-1:0] out_nchunks;

    modport master (
        output in_valid, in_chunk, in_last, in_sext, out_ready,
        input  in_ready, out_valid, out_imm, out_ovf, out_nchunks
    );

    modport slave (
        input  in_valid, in_chunk, in_last, in_sext, out_ready,
        output in_ready, out_valid, out_imm, out_ovf, out_nchunks
    );
endinterface

// File: rtl/imm_chunk_extender.sv
// Assembles an immediate from MSB-first chunks, then sign/zero
// extends it to OUT_W bits (flagging overflow when it is too wide).
module imm_chunk_extender #(
    parameter int IN_W       = 2,
    parameter int OUT_W      = 8,
    parameter int MAX_CHUNKS = 4
) (
    input logic clk,
    input logic reset,
    imm_chunk_extender_if.slave bus
);
    localparam int ACC_W = IN_W * MAX_CHUNKS;
    localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sext;
    logic             sext_nxt;
    logic             load;
    logic             accept;

    logic [OUT_W-1:0] res_imm;
    logic             res_ovf;
    logic             fill;
    int               w;

    logic             valid_q;
    logic [OUT_W-1:0] imm_q;
    logic             ovf_q;
    logic [CNT_W-1:0] nch_q;

    assign bus.in_ready    = (state != HOLD);
    assign accept          = bus.in_valid && bus.in_ready;
    assign bus.out_valid   = valid_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_ovf     = ovf_q;
    assign bus.out_nchunks = nch_q;

    // Next state and next accumulator; load marks the final chunk.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = count;
        sext_nxt  = sext;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt  = ACC_W'(bus.in_chunk);
                    cnt_nxt  = CNT_W'(1);
                    sext_nxt = bus.in_sext;
                    if (bus.in_last) begin
                        state_nxt = HOLD;
                        load      = 1'b1;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_nxt = (acc << IN_W) | ACC_W'(bus.in_chunk);
                    cnt_nxt = count + CNT_W'(1);
                    if (bus.in_last || cnt_nxt == CNT_W'(MAX_CHUNKS)) begin
                        state_nxt = HOLD;
                        load      = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Extend the assembled value by its effective width W = count*IN_W.
    always_comb begin
        w    = int'(cnt_nxt) * IN_W;
        fill = 1'b0;
        for (int k = 0; k < ACC_W; k++) begin
            if (k == w - 1) begin
                fill = acc_nxt[k];
            end
        end
        fill    = fill & sext_nxt;
        res_ovf = (w > OUT_W);
        res_imm = OUT_W'(acc_nxt);
        if (!res_ovf) begin
            for (int i = 0; i < OUT_W; i++) begin
                if (i >= w) begin
                    res_imm[i] = fill;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Accumulator and registered result, captured on the final accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            count   <= '0;
            sext    <= 1'b0;
            valid_q <= 1'b0;
            imm_q   <= '0;
            ovf_q   <= 1'b0;
            nch_q   <= '0;
        end else begin
            acc   <= acc_nxt;
            count <= cnt_nxt;
            sext  <= sext_nxt;
            if (load) begin
                valid_q <= 1'b1;
                imm_q   <= res_imm;
                ovf_q   <= res_ovf;
                nch_q   <= cnt_nxt;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_imm_chunk_extender.sv
// Bench for imm_chunk_extender: an 8-bit and a 6-bit build driven
// in lockstep and checked against an arithmetic reference model.
module tb_imm_chunk_extender;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    imm_chunk_extender_if #(.IN_W(2), .OUT_W(8), .MAX_CHUNKS(4)) b8 ();
    imm_chunk_extender_if #(.IN_W(2), .OUT_W(6), .MAX_CHUNKS(4)) b6 ();

    imm_chunk_extender #(.IN_W(2), .OUT_W(8), .MAX_CHUNKS(4)) dut8 (
        .clk(clk), .reset(reset), .bus(b8.slave)
    );
    imm_chunk_extender #(.IN_W(2), .OUT_W(6), .MAX_CHUNKS(4)) dut6 (
        .clk(clk), .reset(reset), .bus(b6.slave)
    );

    int tests = 0;
    int fails = 0;
    int chs[4];
    logic [63:0] e8, e6;
    logic o8, o6;
    int legacy[4] = '{'h00, 'h01, 'hFE, 'hFF};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer value of the chunks, reinterpreted by width.
    function automatic void model(input int n, input bit sx, input int ow,
                                  output logic [63:0] imm, output logic ovf);
        longint v = 0;
        int wd = 2 * n;
        for (int i = 0; i < n; i++) v = v * 4 + chs[i];
        if (wd <= ow) begin
            if (sx && v >= (longint'(1) << (wd - 1))) v = v - (longint'(1) << wd);
            ovf = 1'b0;
        end else begin
            ovf = 1'b1;
        end
        imm = 64'(v & ((longint'(1) << ow) - 1));
    endfunction

    task automatic drive(input logic v, input int c, input logic l, input logic s);
        b8.in_valid = v; b8.in_chunk = 2'(c); b8.in_last = l; b8.in_sext = s;
        b6.in_valid = v; b6.in_chunk = 2'(c); b6.in_last = l; b6.in_sext = s;
    endtask

    task automatic set_or(input logic r);
        b8.out_ready = r;
        b6.out_ready = r;
    endtask

    task automatic put_chunk(input int c, input logic l, input logic s);
        int t = 0;
        @(negedge clk);
        drive(1'b1, c, l, s);
        while (!(b8.in_ready && b6.in_ready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", 64'(t < 20), 64'd1);
        chk("valid_before_last", 64'(b8.out_valid), 64'd0);
        @(posedge clk);
    endtask

    task automatic check_result(input int n, input bit sx);
        model(n, sx, 8, e8, o8);
        model(n, sx, 6, e6, o6);
        @(negedge clk);
        drive(1'b0, 0, 1'b0, 1'b0);
        chk("out_valid8", 64'(b8.out_valid), 64'd1);
        chk("out_imm8", 64'(b8.out_imm), e8);
        chk("out_ovf8", 64'(b8.out_ovf), 64'(o8));
        chk("out_nchunks8", 64'(b8.out_nchunks), 64'(n));
        chk("out_valid6", 64'(b6.out_valid), 64'd1);
        chk("out_imm6", 64'(b6.out_imm), e6);
        chk("out_ovf6", 64'(b6.out_ovf), 64'(o6));
        chk("in_ready_hold", 64'(b8.in_ready), 64'd0);
    endtask

    task automatic hold_check(input int h);
        for (int i = 0; i < h; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(b8.out_valid), 64'd1);
            chk("hold_imm8", 64'(b8.out_imm), e8);
            chk("hold_imm6", 64'(b6.out_imm), e6);
            chk("hold_in_ready", 64'(b8.in_ready), 64'd0);
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        set_or(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_or(1'b0);
        chk("release_valid", 64'(b8.out_valid), 64'd0);
        chk("release_in_ready", 64'(b8.in_ready), 64'd1);
    endtask

    task automatic run_imm(input int n, input bit sx, input bit sxl,
                           input bit impl, input int hold, input bit rel);
        for (int i = 0; i < n; i++) begin
            put_chunk(chs[i], (i == n - 1) && !impl, (i == 0) ? sx : sxl);
        end
        check_result(n, sx);
        hold_check(hold);
        if (rel) release_out();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b0);
        set_or(1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(b8.out_valid), 64'd0);
        chk("rst_out_imm", 64'(b8.out_imm), 64'd0);
        chk("rst_out_ovf", 64'(b8.out_ovf), 64'd0);
        chk("rst_out_nchunks", 64'(b8.out_nchunks), 64'd0);
        chk("rst_in_ready", 64'(b8.in_ready), 64'd1);

        for (int c = 0; c < 4; c++) begin
            chs[0] = c;
            run_imm(1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
            chk("legacy_map", 64'(b8.out_imm), 64'(legacy[c]));
            release_out();
        end

        chs[0] = 3; chs[1] = 0;
        run_imm(2, 1'b1, 1'b1, 1'b0, 1, 1'b0);
        chk("two_sext", 64'(b8.out_imm), 64'hFC);
        release_out();
        run_imm(2, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        chk("two_zext_toggle", 64'(b8.out_imm), 64'h0C);
        release_out();

        chs[0] = 2; chs[1] = 1; chs[2] = 3; chs[3] = 1;
        run_imm(4, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        chk("implicit_imm8", 64'(b8.out_imm), 64'h9D);
        chk("implicit_n", 64'(b8.out_nchunks), 64'd4);
        chk("ovf_imm6", 64'(b6.out_imm), 64'h1D);
        chk("ovf_flag6", 64'(b6.out_ovf), 64'd1);

        // Back-pressure with a chunk waiting at the input.
        @(negedge clk);
        drive(1'b1, 1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 64'(b8.in_ready), 64'd0);
            chk("bp_valid", 64'(b8.out_valid), 64'd1);
            chk("bp_imm", 64'(b8.out_imm), 64'h9D);
            @(negedge clk);
        end
        set_or(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_or(1'b0);
        chk("bp_release_valid", 64'(b8.out_valid), 64'd0);
        chk("bp_release_ready", 64'(b8.in_ready), 64'd1);
        @(posedge clk);
        chs[0] = 1;
        check_result(1, 1'b1);
        chk("bp_pending_imm", 64'(b8.out_imm), 64'h01);
        release_out();

        // Reset in the middle of an immediate.
        put_chunk(3, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 64'(b8.out_valid), 64'd0);
        chk("midrst_imm", 64'(b8.out_imm), 64'd0);
        reset = 1'b0;
        chs[0] = 1;
        run_imm(1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        chk("midrst_result", 64'(b8.out_imm), 64'h01);
        chk("midrst_n", 64'(b8.out_nchunks), 64'd1);
        release_out();

        for (int it = 0; it < 40; it++) begin
            int n;
            bit impl;
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) chs[i] = int'($urandom_range(0, 3));
            impl = (n == 4) && ($urandom_range(0, 1) == 1);
            run_imm(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    impl, int'($urandom_range(0, 2)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imm_chunk_extender.md
Name: imm_chunk_extender

Overview:
- Successor to the fixed 2-bit-to-8-bit immediate extender in the datapath.
- Builds a wide immediate from a sequence of narrow instruction chunks (prefix-style), then sign- or zero-extends the assembled value to OUT_W bits.
- Sits between instruction decode and the ALU B-operand mux.
- Uses valid/ready on both sides so decode can stall and the ALU can back-pressure.

Parameters:
- IN_W, 2, width of one immediate chunk from the instruction field.
- OUT_W, 8, width of the extended immediate delivered to the datapath.
- MAX_CHUNKS, 4, maximum chunks per immediate; the MAX_CHUNKS-th chunk is an implicit last.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  chunk present on in_chunk.
- in_ready  out  1  block accepts a chunk this cycle.
- in_chunk  in  IN_W  immediate chunk, most-significant chunk first.
- in_last  in  1  this chunk completes the immediate.
- in_sext  in  1  1 = sign-extend, 0 = zero-extend; sampled with the first chunk only.
- out_valid  out  1  out_imm, out_ovf and out_nchunks are valid.
- out_ready  in  1  consumer takes the result this cycle.
- out_imm  out  OUT_W  extended immediate.
- out_ovf  out  1  assembled width exceeded OUT_W; high bits were dropped.
- out_nchunks  out  clog2(MAX_CHUNKS+1)  number of chunks in this result.

Behaviour:
- Reset is asynchronous, active-high. While asserted and after release:
  - state = IDLE; accumulator and count = 0; sext flag = 0.
  - out_valid = 0, out_imm = 0, out_ovf = 0, out_nchunks = 0.
  - in_ready = 1 in the first cycle after release.
- Reset in mid-accumulation or in HOLD discards all partial or pending data. No output is produced for that immediate.
- States:
  - IDLE: in_ready = 1. On an accepted chunk: acc = chunk, count = 1, latch in_sext. Go to HOLD if in_last, else ACCUM.
  - ACCUM: in_ready = 1. On an accepted chunk: acc = (acc << IN_W) | chunk, count += 1. Go to HOLD if in_last or the new count == MAX_CHUNKS.
  - HOLD: in_ready = 0; outputs stable. When out_valid & out_ready, go to IDLE next cycle, with out_valid = 0 in that cycle. There is no same-cycle bypass, so peak throughput is one immediate per (chunks + 1) cycles.
- A chunk is accepted when in_valid & in_ready. in_sext is ignored after the first chunk. in_last on the first chunk gives a single-chunk immediate.
- Result registration: out_* are registered on the accepting edge of the final chunk. out_valid rises 1 cycle after that accept.
- Arithmetic: effective width W = count*IN_W.
  - If W <= OUT_W: out_imm = acc[W-1:0] extended. Fill bits = acc[W-1] if sext, else 0. out_ovf = 0.
  - If W > OUT_W: out_imm = acc[OUT_W-1:0], out_ovf = 1. No extension is applied.
- Legacy equivalence: with a single chunk, IN_W = 2, OUT_W = 8 and sext = 1, the mapping must be 00→00, 01→01, 10→FE, 11→FF.
- Holding in_valid while in_ready = 0 has no effect. The chunk is not consumed and must be re-presented.
- out_ready while out_valid = 0 is ignored.

Test Plan:
- Legacy map, sext = 1, single chunk (in_last = 1): chunks 00/01/10/11 → out_imm 0x00/0x01/0xFE/0xFF, out_nchunks = 1, out_ovf = 0, out_valid 1 cycle after accept.
- Two chunks 11, 00, in_sext = 1 → out_imm 0xFC, out_nchunks = 2. Repeat with in_sext = 0 → 0x0C. Also toggle in_sext to 1 on the second chunk of the zero-extend run → result still 0x0C.
- Implicit last: chunks 10, 01, 11, 01 with in_last = 0 throughout → after the 4th accept, out_imm = 0x9D, out_nchunks = 4, in_ready = 0.
- Overflow, OUT_W = 6 build: the same four chunks → out_imm = 6'h1D, out_ovf = 1.
- Back-pressure: hold out_ready = 0 for 5 cycles after out_valid. Outputs must stay stable and in_ready = 0, and a chunk presented meanwhile is not consumed. Then out_ready = 1 → IDLE next cycle and the pending chunk is accepted.
- Reset mid-operation: accept chunk 11 (in_last = 0), assert reset for 1 cycle, then send a single chunk 01 with in_last = 1 → out_imm 0x01, out_nchunks = 1, with no trace of the discarded chunk.
